// File: rtl/obf_seqgen_pkg.sv
// -----------------------------------------------------------------------------
// obf_seqgen_pkg
// Shared types, constants and table contents for the obfuscation sequence
// generator (obf_seqgen) and its lookup table (obf_seqrom).
//
// Contents:
//   IDX_W / MAX_SEQ_LEN / LEN_W  index width, longest sequence, count width
//   IDX_INVALID                  all-ones index = unsupported, pass-through
//   obf_mode_e                   per-word merge mode (PASS/ORIG/MRG/MRGD)
//   seq_entry_t                  one table entry {valid, len-1, tmpl[], mode[]}
//   seq_merge()                  builds an output word from template + insn
//   seq_entry_alt0/alt1()        default table contents
//
// Optional feature macro: OBF_SEQ_RANDSEL_EN (adds alternative-1 contents).
// -----------------------------------------------------------------------------
package obf_seqgen_pkg;

  localparam int IDX_W       = 7;
  localparam int MAX_SEQ_LEN = 4;
  localparam int LEN_W       = 2;

  localparam logic [IDX_W-1:0] IDX_INVALID = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_NOP     = 7'd4;
  localparam logic [IDX_W-1:0] IDX_ADD     = 7'd64;
  localparam logic [15:0]      LFSR_SEED   = 16'hACE1;

  localparam logic [31:0] TMPL_NOP = 32'h1500_0000;  // l.nop 0
  localparam logic [31:0] TMPL_ADD = 32'hE000_0000;  // l.add with empty regs
  localparam logic [31:0] TMPL_ORI = 32'hA800_0000;  // l.ori with empty regs

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_ORIG = 2'd1,
    MODE_MRG  = 2'd2,
    MODE_MRGD = 2'd3
  } obf_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } seq_state_e;

  // len holds (number of words - 1)
  typedef struct packed {
    logic                             valid;
    logic [LEN_W-1:0]                 len;
    logic [MAX_SEQ_LEN-1:0][31:0]     tmpl;
    logic [MAX_SEQ_LEN-1:0][1:0]      mode;
  } seq_entry_t;

  // MRG copies rD/rA/rB (bits 25:11) into the template; MRGD copies rD into
  // both the rD and rA fields so the second word operates on rD in place.
  function automatic logic [31:0] seq_merge(input logic [31:0] tmpl,
                                            input logic [1:0]  mode,
                                            input logic [31:0] insn);
    logic [31:0] w;
    case (mode)
      MODE_PASS: w = tmpl;
      MODE_ORIG: w = insn;
      MODE_MRG:  w = tmpl | {6'b0, insn[25:11], 11'b0};
      MODE_MRGD: w = tmpl | {6'b0, insn[25:21], insn[25:21], 16'b0};
      default:   w = insn;
    endcase
    return w;
  endfunction

  function automatic seq_entry_t seq_entry_alt0(input logic [IDX_W-1:0] idx);
    seq_entry_t e;
    e         = '0;
    e.valid   = 1'b1;
    e.mode[0] = MODE_ORIG;
    case (idx)
      IDX_NOP: begin
        e.len     = 2'd1;
        e.tmpl[0] = TMPL_NOP;
        e.tmpl[1] = TMPL_NOP;
        e.mode[0] = MODE_PASS;
        e.mode[1] = MODE_PASS;
      end
      IDX_ADD: begin
        e.len     = 2'd1;
        e.tmpl[0] = TMPL_ADD;
        e.tmpl[1] = TMPL_ORI;
        e.mode[0] = MODE_MRG;
        e.mode[1] = MODE_MRGD;
      end
      IDX_INVALID: begin
        e.valid = 1'b0;
      end
      default: begin
        e.len = 2'd0;
      end
    endcase
    return e;
  endfunction

`ifdef OBF_SEQ_RANDSEL_EN
  // Alternative 1 pads the supported sequences with one more nop.
  function automatic seq_entry_t seq_entry_alt1(input logic [IDX_W-1:0] idx);
    seq_entry_t e;
    e = seq_entry_alt0(idx);
    case (idx)
      IDX_NOP, IDX_ADD: begin
        e.len     = 2'd2;
        e.tmpl[2] = TMPL_NOP;
        e.mode[2] = MODE_PASS;
      end
      default: begin
        e.len = e.len;
      end
    endcase
    return e;
  endfunction
`endif

endpackage

// File: rtl/obf_seqgen_if.sv
// -----------------------------------------------------------------------------
// obf_seqgen_if
// Handshake bundle between the index generator (input side), obf_seqgen and
// the decode stage (output side).
//
// Signals:
//   in_valid/in_ready/in_insn/in_index  fetched insn + obfuscation index
//   flush                               abort current sequence
//   out_valid/out_ready/out_insn        emitted words toward decode
//   out_last/out_obf                    last word of sequence / from table
// Modports:
//   master  environment side (drives inputs, accepts outputs)
//   slave   obf_seqgen side
// -----------------------------------------------------------------------------
interface obf_seqgen_if;
  import obf_seqgen_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_insn;
  logic [IDX_W-1:0] in_index;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_insn;
  logic             out_last;
  logic             out_obf;

  modport master (
    output in_valid, in_insn, in_index, flush, out_ready,
    input  in_ready, out_valid, out_insn, out_last, out_obf
  );

  modport slave (
    input  in_valid, in_insn, in_index, flush, out_ready,
    output in_ready, out_valid, out_insn, out_last, out_obf
  );
endinterface

// File: rtl/obf_seqrom.sv
// -----------------------------------------------------------------------------
// obf_seqrom
// Substitution table lookup. The entry for {rd_index[, rd_alt]} is captured
// into entry_q when rd_en is high, so the held entry drives the rest of a
// sequence. The first-word fields of the entry being read are also exposed so
// the caller can register word 0 in the same cycle it accepts the input.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_en               capture the looked-up entry
//   rd_index            obfuscation index
//   rd_alt              alternative select (only with OBF_SEQ_RANDSEL_EN)
//   rd_valid_s/rd_len_s/rd_tmpl0_s/rd_mode0_s  preview of entry being read
//   entry_q             captured entry
// -----------------------------------------------------------------------------
module obf_seqrom
  import obf_seqgen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_index,
`ifdef OBF_SEQ_RANDSEL_EN
  input  logic             rd_alt,
`endif
  output logic             rd_valid_s,
  output logic [LEN_W-1:0] rd_len_s,
  output logic [31:0]      rd_tmpl0_s,
  output logic [1:0]       rd_mode0_s,
  output seq_entry_t       entry_q
);

  seq_entry_t rd_entry_s;
  seq_entry_t entry_d;

  // Table read and capture-enable mux
  always_comb begin
`ifdef OBF_SEQ_RANDSEL_EN
    rd_entry_s = rd_alt ? seq_entry_alt1(rd_index) : seq_entry_alt0(rd_index);
`else
    rd_entry_s = seq_entry_alt0(rd_index);
`endif
    entry_d = rd_en ? rd_entry_s : entry_q;
  end

  assign rd_valid_s = rd_entry_s.valid;
  assign rd_len_s   = rd_entry_s.len;
  assign rd_tmpl0_s = rd_entry_s.tmpl[0];
  assign rd_mode0_s = rd_entry_s.mode[0];

  // Entry register
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/obf_seqgen.sv
// -----------------------------------------------------------------------------
// obf_seqgen
// Expands each fetched instruction into a functionally equivalent sequence of
// 1..MAX_SEQ_LEN words taken from obf_seqrom. Unsupported indices (all-ones)
// or invalid entries pass the original instruction through once.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   obf_seqgen_if.slave: in_valid/in_ready/in_insn/in_index, flush,
//         out_valid/out_ready/out_insn/out_last/out_obf
//
// Optional feature macro: OBF_SEQ_RANDSEL_EN -- a 16-bit LFSR
// (x^16+x^14+x^13+x^11+1, seed 16'hACE1) picks one of two table alternatives
// at input acceptance.
//
// in_ready is registered idle state OR'd with the final handshake of the
// current sequence, which lets a new input be accepted with no bubble.
// -----------------------------------------------------------------------------
module obf_seqgen
  import obf_seqgen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  obf_seqgen_if.slave bus
);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      insn_q, insn_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_insn_q, out_insn_d;
  logic             out_last_q, out_last_d;
  logic             out_obf_q, out_obf_d;

  logic             hs_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [LEN_W-1:0] nxt_cnt_s;

  logic             rd_valid_s;
  logic [LEN_W-1:0] rd_len_s;
  logic [31:0]      rd_tmpl0_s;
  logic [1:0]       rd_mode0_s;
  seq_entry_t       entry_q;

`ifdef OBF_SEQ_RANDSEL_EN
  logic [15:0] lfsr_q, lfsr_d;
  // LFSR step, runs every cycle
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  assign hs_s       = out_valid_q & bus.out_ready;
  assign in_ready_s = (state_q == ST_IDLE) | (hs_s & out_last_q);
  assign accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
  assign nxt_cnt_s  = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

  obf_seqrom u_seqrom (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (accept_s),
    .rd_index   (bus.in_index),
`ifdef OBF_SEQ_RANDSEL_EN
    .rd_alt     (lfsr_q[0]),
`endif
    .rd_valid_s (rd_valid_s),
    .rd_len_s   (rd_len_s),
    .rd_tmpl0_s (rd_tmpl0_s),
    .rd_mode0_s (rd_mode0_s),
    .entry_q    (entry_q)
  );

  // Next-state / next-output logic; flush outranks accept and advance
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    insn_d      = insn_q;
    out_valid_d = out_valid_q;
    out_insn_d  = out_insn_q;
    out_last_d  = out_last_q;
    out_obf_d   = out_obf_q;
    if (bus.flush) begin
      state_d     = ST_IDLE;
      cnt_d       = {LEN_W{1'b0}};
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_obf_d   = 1'b0;
    end else if (accept_s) begin
      state_d     = ST_EMIT;
      cnt_d       = {LEN_W{1'b0}};
      insn_d      = bus.in_insn;
      out_valid_d = 1'b1;
      if (rd_valid_s) begin
        out_insn_d = seq_merge(rd_tmpl0_s, rd_mode0_s, bus.in_insn);
        out_last_d = (rd_len_s == {LEN_W{1'b0}});
        out_obf_d  = 1'b1;
      end else begin
        out_insn_d = bus.in_insn;
        out_last_d = 1'b1;
        out_obf_d  = 1'b0;
      end
    end else if (hs_s) begin
      if (out_last_q) begin
        state_d     = ST_IDLE;
        cnt_d       = {LEN_W{1'b0}};
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_obf_d   = 1'b0;
      end else begin
        // out_last stops the count at len, so cnt never wraps
        cnt_d      = nxt_cnt_s;
        out_insn_d = seq_merge(entry_q.tmpl[nxt_cnt_s], entry_q.mode[nxt_cnt_s], insn_q);
        out_last_d = (nxt_cnt_s == entry_q.len);
        out_obf_d  = entry_q.valid;
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {LEN_W{1'b0}};
      insn_q      <= 32'h0;
      out_valid_q <= 1'b0;
      out_insn_q  <= 32'h0;
      out_last_q  <= 1'b0;
      out_obf_q   <= 1'b0;
`ifdef OBF_SEQ_RANDSEL_EN
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      insn_q      <= insn_d;
      out_valid_q <= out_valid_d;
      out_insn_q  <= out_insn_d;
      out_last_q  <= out_last_d;
      out_obf_q   <= out_obf_d;
`ifdef OBF_SEQ_RANDSEL_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_insn  = out_insn_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_obf   = out_obf_q;

endmodule
